// File: rtl/pwm_pkg.sv
// pwm_multi shared types and helpers.
// Sequencer states, duty ceiling and the duty clamp.
package pwm_pkg;

  localparam int DUTY_MAX = 100;

  typedef enum logic [1:0] {
    CONT,
    IDLE,
    RUN,
    GAP
  } seq_e;

  function automatic logic [7:0] duty_clamp(
    input logic [7:0] d
  );
    return (d > 8'(DUTY_MAX)) ? 8'(DUTY_MAX) : d;
  endfunction

endpackage

// File: rtl/pwm_burst_fsm.sv
// Burst sequencer for pwm_multi.
// Advances only on period boundaries, from shadowed controls.
module pwm_burst_fsm
  import pwm_pkg::*;
#(
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bnd,
  input  logic               start,
  input  logic               mode_sh,
  input  logic               type_sh,
  input  logic [BURST_W-1:0] len_sh,
  output logic               gate,
  output logic               active
);

  seq_e               state_q, state_d;
  logic [BURST_W-1:0] bcnt_q, bcnt_d;
  logic               pend_q, pend_d;
  logic               req;
  logic               last;

  assign req  = pend_q | start;
  assign last = ({1'b0, bcnt_q} + (BURST_W+1)'(1))
             >= {1'b0, len_sh};

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    pend_d  = req;
    if (bnd) begin
      // A request survives a boundary only by starting a burst.
      pend_d = 1'b0;
      if (!mode_sh) begin
        state_d = CONT;
      end else begin
        unique case (state_q)
          CONT: state_d = IDLE;
          IDLE: begin
            if (req && (len_sh != '0)) begin
              state_d = RUN;
              bcnt_d  = '0;
            end
          end
          RUN: begin
            if (last) begin
              state_d = type_sh ? GAP : IDLE;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + BURST_W'(1);
            end
          end
          GAP: begin
            if (last) begin
              state_d = RUN;
              bcnt_d  = '0;
            end else begin
              bcnt_d = bcnt_q + BURST_W'(1);
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONT;
      bcnt_q  <= '0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      pend_q  <= pend_d;
    end
  end

  assign gate   = (state_q == CONT) || (state_q == RUN);
  assign active = (state_q == RUN);

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel phase-aligned PWM with shadowed config
// and a burst sequencer.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               sysclk,
  input  logic               reset,
  input  logic [CNT_W-1:0]   period,
  input  logic [8*NCH-1:0]   duty,
  input  logic [NCH-1:0]     ch_en,
  input  logic               burstmode,
  input  logic               bursttype,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  output logic [NCH-1:0]     pwm,
  output logic               period_tick,
  output logic               burst_active
);

  localparam int PW = CNT_W + 7;

  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   per_sh;
  logic [8*NCH-1:0]   duty_sh;
  logic [NCH-1:0]     en_sh;
  logic               bm_sh;
  logic               bt_sh;
  logic [BURST_W-1:0] len_sh;
  logic               run;
  logic               bnd;
  logic               gate;
  logic               active;
  logic [NCH-1:0]     on;

  assign run = (per_sh != '0);
  assign bnd = !run || (cnt == per_sh - CNT_W'(1));

  // Shadows follow inputs every cycle while stopped.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      per_sh  <= '0;
      duty_sh <= '0;
      en_sh   <= '0;
      bm_sh   <= 1'b0;
      bt_sh   <= 1'b0;
      len_sh  <= '0;
    end else if (bnd) begin
      cnt     <= '0;
      per_sh  <= period;
      duty_sh <= duty;
      en_sh   <= ch_en;
      bm_sh   <= burstmode;
      bt_sh   <= bursttype;
      len_sh  <= burst_len;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [PW-1:0] lhs;
    logic [PW-1:0] rhs;
    assign lhs = PW'(cnt) * PW'(DUTY_MAX);
    assign rhs = PW'(per_sh)
               * PW'(duty_clamp(duty_sh[8*g +: 8]));
    assign on[g] = (lhs < rhs);
  end

  pwm_burst_fsm #(
    .BURST_W (BURST_W)
  ) u_fsm (
    .clk     (sysclk),
    .rst_n   (reset),
    .bnd     (bnd),
    .start   (start),
    .mode_sh (bm_sh),
    .type_sh (bt_sh),
    .len_sh  (len_sh),
    .gate    (gate),
    .active  (active)
  );

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      pwm          <= '0;
      period_tick  <= 1'b0;
      burst_active <= 1'b0;
    end else begin
      pwm          <= en_sh & on & {NCH{gate & run}};
      period_tick  <= run && (cnt == '0);
      burst_active <= active;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a period-level
// reference model and per-cycle scoreboard.
module tb_pwm_multi;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic [15:0] period;
  logic [31:0] duty;
  logic [3:0]  ch_en;
  logic        burstmode;
  logic        bursttype;
  logic [7:0]  burst_len;
  logic        start;
  logic [3:0]  pwm;
  logic        period_tick;
  logic        burst_active;

  pwm_multi #(
    .NCH     (4),
    .CNT_W   (16),
    .BURST_W (8)
  ) dut (
    .sysclk       (sysclk),
    .reset        (reset),
    .period       (period),
    .duty         (duty),
    .ch_en        (ch_en),
    .burstmode    (burstmode),
    .bursttype    (bursttype),
    .burst_len    (burst_len),
    .start        (start),
    .pwm          (pwm),
    .period_tick  (period_tick),
    .burst_active (burst_active)
  );

  always #5 sysclk = ~sysclk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: position in period, config
  // snapshot per period, mode 0=cont 1=idle 2=run 3=gap
  // with a countdown of periods left in run/gap.
  int         m_P, m_pos, m_len, m_mode, m_left;
  int         m_dc, m_hi;
  logic [7:0] m_d [4];
  logic [3:0] m_en;
  bit         m_bm, m_bt, m_pend, m_bnd, m_req;
  logic [3:0] exp_pwm;
  logic       exp_tick, exp_ba;

  always @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      m_P = 0; m_pos = 0; m_len = 0;
      m_mode = 0; m_left = 0;
      for (int i = 0; i < 4; i++) m_d[i] = 0;
      m_en = 0; m_bm = 0; m_bt = 0; m_pend = 0;
      exp_pwm = 0; exp_tick = 0; exp_ba = 0;
    end else begin
      exp_tick = (m_P != 0) && (m_pos == 0);
      exp_ba   = (m_mode == 2);
      for (int i = 0; i < 4; i++) begin
        m_dc = (m_d[i] > 100) ? 100 : int'(m_d[i]);
        m_hi = (m_P * m_dc + 99) / 100;
        exp_pwm[i] = (m_P != 0) && m_en[i]
                  && (m_mode == 0 || m_mode == 2)
                  && (m_pos < m_hi);
      end
      m_bnd = (m_P == 0) || (m_pos == m_P - 1);
      m_req = m_pend | start;
      if (m_bnd) begin
        if (!m_bm) m_mode = 0;
        else case (m_mode)
          0: m_mode = 1;
          1: if (m_req && m_len != 0) begin
               m_mode = 2; m_left = m_len;
             end
          2: if (m_left <= 1) begin
               m_mode = m_bt ? 3 : 1; m_left = m_len;
             end else m_left--;
          default: if (m_left <= 1) begin
               m_mode = 2; m_left = m_len;
             end else m_left--;
        endcase
        m_pend = 0;
        m_pos  = 0;
        m_P    = int'(period);
        for (int i = 0; i < 4; i++)
          m_d[i] = duty[8*i +: 8];
        m_en  = ch_en;
        m_bm  = burstmode;
        m_bt  = bursttype;
        m_len = int'(burst_len);
      end else begin
        m_pos++;
        m_pend = m_req;
      end
    end
  end

  always @(negedge sysclk) begin
    if (chk_en && reset) begin
      check("sb_pwm", 32'(pwm), 32'(exp_pwm));
      check("sb_tick", 32'(period_tick), 32'(exp_tick));
      check("sb_ba", 32'(burst_active), 32'(exp_ba));
    end
  end

  int h[4];
  int tk, ban, rise;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sysclk);
      #1;
    end
  endtask

  task automatic measure(input int n);
    logic prev;
    for (int i = 0; i < 4; i++) h[i] = 0;
    tk = 0; ban = 0; rise = 0;
    prev = pwm[0];
    repeat (n) begin
      for (int i = 0; i < 4; i++) h[i] += int'(pwm[i]);
      tk   += int'(period_tick);
      ban  += int'(burst_active);
      rise += int'(pwm[0] && !prev);
      prev  = pwm[0];
      step(1);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int c;
    period = 16'd40;
    duty = {8'd0, 8'd25, 8'd50, 8'd90};
    ch_en = 4'hF;
    burstmode = 0; bursttype = 0;
    burst_len = 0; start = 0;
    step(2);
    check("rst_pwm", 32'(pwm), 0);
    check("rst_tick", 32'(period_tick), 0);
    check("rst_ba", 32'(burst_active), 0);
    chk_en = 1;
    reset = 1'b1;

    // continuous, 40-cycle period
    step(5);
    measure(40);
    check("c90", h[0], 36);
    check("c50", h[1], 20);
    check("c25", h[2], 10);
    check("c0", h[3], 0);
    check("c_tick", tk, 1);

    // duty 100 and clamped 150
    duty = {8'd0, 8'd50, 8'd150, 8'd100};
    step(45);
    measure(80);
    check("d100", h[0], 80);
    check("d150", h[1], 80);
    check("d50", h[2], 40);

    // stopped
    period = 16'd0;
    step(45);
    measure(40);
    check("p0_pwm", h[0] + h[1] + h[2], 0);
    check("p0_tick", tk, 0);

    // single burst
    period = 16'd10;
    duty = {4{8'd50}};
    burstmode = 1; bursttype = 0;
    burst_len = 8'd3;
    do_reset();
    step(25);
    pulse_start();
    measure(60);
    check("b1_hi", h[0], 15);
    check("b1_ba", ban, 30);
    check("b1_rise", rise, 3);
    step(5);
    pulse_start();
    measure(60);
    check("b2_hi", h[0], 15);
    check("b2_ba", ban, 30);
    check("b2_rise", rise, 3);

    // repeating burst/gap
    bursttype = 1; burst_len = 8'd2;
    step(25);
    pulse_start();
    step(12);
    measure(80);
    check("rep_hi", h[0], 20);
    check("rep_ba", ban, 40);
    burstmode = 0;
    step(30);
    measure(20);
    check("back_hi", h[0], 10);
    check("back_ba", ban, 0);

    // mid-period duty change
    period = 16'd20;
    duty = {4{8'd50}};
    burstmode = 0;
    do_reset();
    step(2);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      c += int'(pwm[0]);
      if (k == 5) duty = {4{8'd80}};
      step(1);
    end
    check("dc_p1", c, 10);
    c = 0;
    for (int k = 0; k < 20; k++) begin
      c += int'(pwm[0]);
      step(1);
    end
    check("dc_p2", c, 16);

    // single-cycle period
    period = 16'd1;
    duty = {8'd100, 8'd50, 8'd1, 8'd0};
    step(25);
    measure(10);
    check("p1_tick", tk, 10);
    check("p1_d0", h[0], 0);
    check("p1_d1", h[1], 10);
    check("p1_d50", h[2], 10);

    // async reset in the middle of a burst pulse
    period = 16'd10;
    duty = {4{8'd50}};
    burstmode = 1; bursttype = 0;
    burst_len = 8'd3;
    step(25);
    pulse_start();
    w = 0;
    while (!(pwm[0] && burst_active) && w < 50) begin
      step(1);
      w++;
    end
    check("mid_found", 32'(w < 50), 1);
    reset = 1'b0;
    #1;
    check("ar_pwm", 32'(pwm), 0);
    check("ar_ba", 32'(burst_active), 0);
    burstmode = 0;
    step(2);
    reset = 1'b1;
    step(30);
    measure(10);
    check("ar_cont", h[0], 5);
    check("ar_ba2", ban, 0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
